imem_fetch_ctrl: RTL and testbench
==================================

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameters SHALL be: ROM_DEPTH, default 32, number of instruction ROM words; HALT_WORD, default 32'h00000012, terminating instruction; START_ADDR, default 0, first word index fetched.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  single-cycle pulse; begins fetch from START_ADDR.
REQ-006 imem_addr  out  32  word index driven to the combinational instruction ROM.
REQ-007 imem_rdata  in  32  ROM word at imem_addr, valid in the same cycle.
REQ-008 redirect_valid  in  1  branch/jump redirect request.
REQ-009 redirect_addr  in  32  word index of the redirect target.
REQ-010 ins_valid  out  1  output instruction register holds a valid instruction.
REQ-011 ins_ready  in  1  consumer accepts the instruction when ins_valid is high.
REQ-012 ins_data  out  32  registered instruction word.
REQ-013 ins_pc  out  32  word index the instruction was fetched from.
REQ-014 halted  out  1  HALT_WORD has been delivered and accepted.
REQ-015 fault  out  1  fetch address reached or exceeded ROM_DEPTH.
REQ-016 fetch_cnt  out  16  count of accepted instructions, saturating at 16'hFFFF.

Function
REQ-017 States SHALL be IDLE, FETCH, DRAIN, HALT, ERR; reset state IDLE.
REQ-018 imem_addr SHALL equal the internal pc register combinationally in every state.
REQ-019 IDLE: start=1 SHALL load pc<=START_ADDR, fetch_cnt<=0, clear halted/fault, next FETCH; all other inputs ignored.
REQ-020 A handshake SHALL occur on any cycle with ins_valid=1 and ins_ready=1; each handshake SHALL increment fetch_cnt (saturating).
REQ-021 FETCH with the output register free (ins_valid=0 or handshake this cycle) and pc<ROM_DEPTH SHALL load ins_data<=imem_rdata, ins_pc<=pc, ins_valid<=1, pc<=pc+1 (32-bit, no wrap).
REQ-022 FETCH with the output register occupied and no handshake SHALL hold pc, ins_data, ins_pc, ins_valid (stall).
REQ-023 A word loaded in FETCH equal to HALT_WORD SHALL move the state to DRAIN; pc SHALL NOT advance past it.
REQ-024 DRAIN SHALL issue no further loads; on handshake of the HALT_WORD the state SHALL go to HALT with ins_valid<=0, halted<=1.
REQ-025 FETCH with the output register free and pc>=ROM_DEPTH SHALL go to ERR with fault<=1, ins_valid<=0, no load.
REQ-026 redirect_valid=1 in FETCH or DRAIN SHALL take priority over every load: pc<=redirect_addr, ins_valid<=0, state FETCH; a handshake in that same cycle SHALL still count in fetch_cnt.
REQ-027 Redirect SHALL be ignored in IDLE, HALT and ERR.
REQ-028 HALT and ERR SHALL hold all outputs; start=1 SHALL restart exactly as from IDLE (REQ-019).
REQ-029 start=1 in FETCH or DRAIN SHALL be ignored.
REQ-030 Latency: first ins_valid SHALL assert two clock edges after the edge sampling start (edge 1 enters FETCH, edge 2 loads the register); throughput SHALL be one instruction per cycle with ins_ready held high.

Reset
REQ-031 rstn=0 SHALL immediately force state IDLE, pc=START_ADDR, ins_valid=0, ins_data=0, ins_pc=0, halted=0, fault=0, fetch_cnt=0, independent of clk.
REQ-032 Reset asserted mid-fetch or mid-stall SHALL discard the held instruction; no handshake SHALL be reported after rstn deasserts until a new start.

Verification
REQ-033 ROM[0..9]={0000008e,0000010e,00110102,0000018e,06518182,00208081,00110102,fe310f11,00008f82,00000012}, ins_ready=1, start pulse -> ins_pc 0..9 on consecutive cycles with matching ins_data, halted=1 the cycle after pc 9 is accepted, fetch_cnt=10.
REQ-034 Same program, ins_ready=0 for 3 cycles after first ins_valid -> ins_data holds 0000008e, ins_pc=0, imem_addr=1 throughout; resumes in order when ins_ready=1.
REQ-035 redirect_valid=1, redirect_addr=2 while ins_pc=5 is valid -> ins_valid=0 next cycle, then ins_pc=2, ins_data=00110102.
REQ-036 ROM with no HALT_WORD, ins_ready=1 -> after ins_pc=31 accepted, fault=1, ins_valid=0, fetch_cnt=32.
REQ-037 rstn pulsed low between clock edges during a stall -> all outputs reset value immediately; new start fetches ins_pc=0 again.
REQ-038 start pulse in HALT -> halted=0, fetch_cnt=0, sequence of REQ-033 repeats.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks a combinational instruction ROM and
// presents one registered instruction at a time on a valid/ready output.
module imem_fetch_ctrl #(
  parameter int unsigned ROM_DEPTH  = 32,
  parameter logic [31:0] HALT_WORD  = 32'h00000012,
  parameter logic [31:0] START_ADDR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_data,
  output logic [31:0] ins_pc,
  output logic        halted,
  output logic        fault,
  output logic [15:0] fetch_cnt
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [31:0] DEPTH = 32'(ROM_DEPTH);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ins_valid_q, ins_valid_d;
  logic [31:0] ins_data_q, ins_data_d;
  logic [31:0] ins_pc_q, ins_pc_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  logic handshake;
  logic out_free;

  assign handshake = ins_valid_q & ins_ready;
  assign out_free  = ~ins_valid_q | handshake;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ins_valid_d = ins_valid_q;
    ins_data_d  = ins_data_q;
    ins_pc_d    = ins_pc_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;

    // Every accepted instruction counts, including one accepted while redirecting.
    if (handshake && (fetch_cnt_q != 16'hFFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 16'd1;
    end

    case (state_q)
      ST_FETCH, ST_DRAIN: begin
        if (redirect_valid) begin
          pc_d        = redirect_addr;
          ins_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end else if (state_q == ST_FETCH) begin
          if (out_free) begin
            if (pc_q < DEPTH) begin
              ins_data_d  = imem_rdata;
              ins_pc_d    = pc_q;
              ins_valid_d = 1'b1;
              // The halt word parks pc on itself so nothing beyond it is fetched.
              if (imem_rdata == HALT_WORD) begin
                state_d = ST_DRAIN;
              end else begin
                pc_d = pc_q + 32'd1;
              end
            end else begin
              ins_valid_d = 1'b0;
              fault_d     = 1'b1;
              state_d     = ST_ERR;
            end
          end
        end else if (handshake) begin
          ins_valid_d = 1'b0;
          halted_d    = 1'b1;
          state_d     = ST_HALT;
        end
      end
      default: begin
        // IDLE, HALT and ERR all restart identically on start.
        if (start) begin
          pc_d        = START_ADDR;
          fetch_cnt_d = 16'd0;
          halted_d    = 1'b0;
          fault_d     = 1'b0;
          ins_valid_d = 1'b0;
          state_d     = ST_FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      pc_q        <= START_ADDR;
      ins_valid_q <= 1'b0;
      ins_data_q  <= 32'd0;
      ins_pc_q    <= 32'd0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      fetch_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_valid_q <= ins_valid_d;
      ins_data_q  <= ins_data_d;
      ins_pc_q    <= ins_pc_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign ins_valid = ins_valid_q;
  assign ins_data  = ins_data_q;
  assign ins_pc    = ins_pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a 32-word ROM model answers imem_addr
// combinationally; each scenario task checks its own hand-computed values.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins_data;
  logic [31:0] ins_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] rom [0:31];
  logic [31:0] prog [0:9] = '{32'h0000008e, 32'h0000010e, 32'h00110102, 32'h0000018e,
                              32'h06518182, 32'h00208081, 32'h00110102, 32'hfe310f11,
                              32'h00008f82, 32'h00000012};

  assign imem_rdata = (imem_addr < 32'd32) ? rom[imem_addr[4:0]] : 32'hDEADBEEF;

  imem_fetch_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .ins_data(ins_data), .ins_pc(ins_pc),
    .halted(halted), .fault(fault), .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 32; i++) rom[i] = 32'h0000_0001;
    for (int i = 0; i < 10; i++) rom[i] = prog[i];
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; ins_ready = 1'b0;
    redirect_valid = 1'b0; redirect_addr = 32'd0;
    load_prog();
    #1;
    checks++;
    if ({ins_valid, halted, fault} !== 3'b000 || ins_data !== 32'd0 || ins_pc !== 32'd0 ||
        fetch_cnt !== 16'd0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b h=%b f=%b d=%h pc=%h cnt=%0d addr=%h exp all zero",
               ins_valid, halted, fault, ins_data, ins_pc, fetch_cnt, imem_addr);
    end
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    redirect_valid = 1'b1; redirect_addr = 32'd7;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'd0 || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_redirect_ignored got addr=%0d v=%b exp addr=0 v=0", imem_addr, ins_valid);
    end
  endtask

  task automatic test_program();
    ins_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (ins_valid !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL prog_latency got v=%b addr=%0d exp v=0 addr=0", ins_valid, imem_addr);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      $display("txn prog pc=%0d data=%h cnt=%0d", ins_pc, ins_data, fetch_cnt);
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 32'(i) || ins_data !== prog[i] ||
          fetch_cnt !== 16'(i) || imem_addr !== ((i == 9) ? 32'd9 : 32'(i + 1))) begin
        errors++;
        $display("FAIL prog_seq[%0d] got v=%b pc=%0d d=%h cnt=%0d addr=%0d exp v=1 pc=%0d d=%h cnt=%0d",
                 i, ins_valid, ins_pc, ins_data, fetch_cnt, imem_addr, i, prog[i], i);
      end
    end
    step();
    checks++;
    if (halted !== 1'b1 || ins_valid !== 1'b0 || fetch_cnt !== 16'd10) begin
      errors++;
      $display("FAIL prog_halt got h=%b v=%b cnt=%0d exp h=1 v=0 cnt=10", halted, ins_valid, fetch_cnt);
    end
    redirect_valid = 1'b1; redirect_addr = 32'd4;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (halted !== 1'b1 || ins_valid !== 1'b0 || imem_addr !== 32'd9 || fetch_cnt !== 16'd10) begin
      errors++;
      $display("FAIL halt_hold got h=%b v=%b addr=%0d cnt=%0d exp h=1 v=0 addr=9 cnt=10",
               halted, ins_valid, imem_addr, fetch_cnt);
    end
  endtask

  task automatic test_stall_restart();
    ins_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (halted !== 1'b0 || fetch_cnt !== 16'd0) begin
      errors++;
      $display("FAIL restart_clear got h=%b cnt=%0d exp h=0 cnt=0", halted, fetch_cnt);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      $display("txn stall k=%0d pc=%0d data=%h addr=%0d", k, ins_pc, ins_data, imem_addr);
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 32'd0 || ins_data !== 32'h0000008e ||
          imem_addr !== 32'd1 || fetch_cnt !== 16'd0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b pc=%0d d=%h addr=%0d cnt=%0d exp v=1 pc=0 d=0000008e addr=1 cnt=0",
                 k, ins_valid, ins_pc, ins_data, imem_addr, fetch_cnt);
      end
      if (k < 3) step();
    end
    ins_ready = 1'b1;
    for (int i = 1; i < 10; i++) begin
      step();
      $display("txn resume pc=%0d data=%h", ins_pc, ins_data);
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 32'(i) || ins_data !== prog[i]) begin
        errors++;
        $display("FAIL resume_seq[%0d] got v=%b pc=%0d d=%h exp v=1 pc=%0d d=%h",
                 i, ins_valid, ins_pc, ins_data, i, prog[i]);
      end
    end
    step();
    checks++;
    if (halted !== 1'b1 || fetch_cnt !== 16'd10) begin
      errors++;
      $display("FAIL stall_halt got h=%b cnt=%0d exp h=1 cnt=10", halted, fetch_cnt);
    end
  endtask

  task automatic test_redirect();
    int n;
    ins_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start = (i == 3);
      step();
      $display("txn redir_pre pc=%0d data=%h", ins_pc, ins_data);
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 32'(i) || ins_data !== prog[i]) begin
        errors++;
        $display("FAIL redir_pre[%0d] got v=%b pc=%0d d=%h exp v=1 pc=%0d d=%h",
                 i, ins_valid, ins_pc, ins_data, i, prog[i]);
      end
    end
    start = 1'b0;
    redirect_valid = 1'b1; redirect_addr = 32'd2;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (ins_valid !== 1'b0 || fetch_cnt !== 16'd6 || imem_addr !== 32'd2) begin
      errors++;
      $display("FAIL redir_flush got v=%b cnt=%0d addr=%0d exp v=0 cnt=6 addr=2", ins_valid, fetch_cnt, imem_addr);
    end
    step();
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'd2 || ins_data !== 32'h00110102) begin
      errors++;
      $display("FAIL redir_target got v=%b pc=%0d d=%h exp v=1 pc=2 d=00110102", ins_valid, ins_pc, ins_data);
    end
    n = 0;
    while (halted !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (halted !== 1'b1 || fetch_cnt !== 16'd14) begin
      errors++;
      $display("FAIL redir_halt got h=%b cnt=%0d exp h=1 cnt=14", halted, fetch_cnt);
    end
  endtask

  task automatic test_fault();
    for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | 32'(i);
    ins_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      step();
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 32'(i) || ins_data !== (32'hA000_0000 | 32'(i))) begin
        errors++;
        $display("FAIL fault_seq[%0d] got v=%b pc=%0d d=%h exp v=1 pc=%0d", i, ins_valid, ins_pc, ins_data, i);
      end
    end
    step();
    $display("txn fault f=%b v=%b cnt=%0d addr=%0d", fault, ins_valid, fetch_cnt, imem_addr);
    checks++;
    if (fault !== 1'b1 || ins_valid !== 1'b0 || fetch_cnt !== 16'd32 || imem_addr !== 32'd32 || halted !== 1'b0) begin
      errors++;
      $display("FAIL fault_enter got f=%b v=%b cnt=%0d addr=%0d h=%b exp f=1 v=0 cnt=32 addr=32 h=0",
               fault, ins_valid, fetch_cnt, imem_addr, halted);
    end
    redirect_valid = 1'b1; redirect_addr = 32'd3;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fault !== 1'b1 || ins_valid !== 1'b0 || imem_addr !== 32'd32) begin
      errors++;
      $display("FAIL err_hold got f=%b v=%b addr=%0d exp f=1 v=0 addr=32", fault, ins_valid, imem_addr);
    end
  endtask

  task automatic test_reset_stall();
    load_prog();
    ins_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (fault !== 1'b0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL err_restart got f=%b addr=%0d exp f=0 addr=0", fault, imem_addr);
    end
    ins_ready = 1'b1;
    repeat (3) step();
    ins_ready = 1'b0;
    step();
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'd2 || fetch_cnt !== 16'd2) begin
      errors++;
      $display("FAIL pre_reset_stall got v=%b pc=%0d cnt=%0d exp v=1 pc=2 cnt=2", ins_valid, ins_pc, fetch_cnt);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({ins_valid, halted, fault} !== 3'b000 || ins_data !== 32'd0 || ins_pc !== 32'd0 ||
        fetch_cnt !== 16'd0 || imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL async_reset got v=%b h=%b f=%b d=%h pc=%h cnt=%0d addr=%h exp all zero",
               ins_valid, halted, fault, ins_data, ins_pc, fetch_cnt, imem_addr);
    end
    #2 rstn = 1'b1;
    ins_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (ins_valid !== 1'b0 || fetch_cnt !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_quiet got v=%b cnt=%0d exp v=0 cnt=0", ins_valid, fetch_cnt);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    $display("txn post_reset pc=%0d data=%h", ins_pc, ins_data);
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'd0 || ins_data !== 32'h0000008e) begin
      errors++;
      $display("FAIL post_reset_fetch got v=%b pc=%0d d=%h exp v=1 pc=0 d=0000008e", ins_valid, ins_pc, ins_data);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_stall_restart();
    test_redirect();
    test_fault();
    test_reset_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
